// File: rtl/dma_bus_arbiter.sv
// Bus arbiter between the 6502 core and two DMA masters: stalls the core on a
// read cycle, then grants the bus round-robin with bounded bursts and turnaround.
module dma_bus_arbiter #(
  parameter int HANDOFF_CYCLES = 1,
  parameter int MAX_BURST      = 16,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_rw,
  input  logic [1:0] dma_req,
  output logic       cpu_ready,
  output logic [1:0] dma_ack,
  output logic [1:0] bus_owner,
  output logic [1:0] stall_writes
);

  typedef enum logic [2:0] {CPU_RUN, REQ_WAIT, TURN, DMA, RETURN} state_t;

  localparam logic [1:0]       HO_LAST   = (HANDOFF_CYCLES == 0) ? 2'd0 : 2'(HANDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  state_t           state, state_nxt;
  logic [1:0]       turn_cnt, turn_cnt_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt, burst_inc;
  logic [1:0]       stall_nxt;
  logic             winner, winner_nxt;
  logic             last_grant, last_grant_nxt;
  logic             handoff_done, burst_exhausted;
  logic             go_turn, go_pick, go_return;
  logic             ready_nxt;
  logic [1:0]       ack_nxt, owner_nxt;

  // Both requesting: alternate away from the last grant; otherwise the lone requester.
  function automatic logic pick_winner(input logic [1:0] req, input logic last);
    if (req == 2'b11) begin
      return ~last;
    end else begin
      return req[1];
    end
  endfunction

  always_comb begin
    state_nxt       = state;
    turn_cnt_nxt    = turn_cnt;
    burst_cnt_nxt   = burst_cnt;
    stall_nxt       = stall_writes;
    winner_nxt      = winner;
    last_grant_nxt  = last_grant;
    go_turn         = 1'b0;
    go_pick         = 1'b0;
    go_return       = 1'b0;
    burst_inc       = burst_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    handoff_done    = (turn_cnt == HO_LAST);
    burst_exhausted = (MAX_BURST != 0) && (burst_inc >= BURST_LIM);

    case (state)
      CPU_RUN: begin
        // Any stay in CPU_RUN lasts at least one ready cycle, which meets the CPU-cycle guarantee.
        if (dma_req != 2'b00) begin
          state_nxt = REQ_WAIT;
        end else begin
          state_nxt = CPU_RUN;
        end
      end
      REQ_WAIT: begin
        if (dma_req == 2'b00) begin
          state_nxt = CPU_RUN;
        end else if (cpu_rw) begin
          go_turn = 1'b1;
        end else if (stall_writes != 2'b11) begin
          stall_nxt = stall_writes + 2'd1;
        end else begin
          stall_nxt = stall_writes;
        end
      end
      TURN: begin
        if (handoff_done) begin
          go_pick = 1'b1;
        end else begin
          turn_cnt_nxt = turn_cnt + 2'd1;
        end
      end
      DMA: begin
        burst_cnt_nxt = burst_inc;
        if (dma_req[winner] && !burst_exhausted) begin
          state_nxt = DMA;
        end else if (dma_req[~winner] && !burst_exhausted) begin
          go_turn = 1'b1;
        end else begin
          go_return = 1'b1;
        end
      end
      RETURN: begin
        if (handoff_done) begin
          state_nxt = CPU_RUN;
        end else begin
          turn_cnt_nxt = turn_cnt + 2'd1;
        end
      end
      default: state_nxt = CPU_RUN;
    endcase

    // With zero handoff cycles a turn collapses straight into the winner pick.
    if (go_turn && (HANDOFF_CYCLES != 0)) begin
      state_nxt    = TURN;
      turn_cnt_nxt = 2'd0;
    end else if (go_turn || go_pick) begin
      if (dma_req != 2'b00) begin
        state_nxt      = DMA;
        winner_nxt     = pick_winner(dma_req, last_grant);
        last_grant_nxt = winner_nxt;
      end else begin
        go_return = 1'b1;
      end
    end else begin
      winner_nxt = winner;
    end

    if (go_return) begin
      if (HANDOFF_CYCLES != 0) begin
        state_nxt    = RETURN;
        turn_cnt_nxt = 2'd0;
      end else begin
        state_nxt = CPU_RUN;
      end
    end else begin
      turn_cnt_nxt = turn_cnt_nxt;
    end

    if ((state_nxt == CPU_RUN) && (state != CPU_RUN)) begin
      burst_cnt_nxt = '0;
      stall_nxt     = 2'd0;
    end else begin
      burst_cnt_nxt = burst_cnt_nxt;
    end

    ready_nxt = (state_nxt == CPU_RUN);
    case (state_nxt)
      DMA: begin
        ack_nxt   = winner_nxt ? 2'b10 : 2'b01;
        owner_nxt = winner_nxt ? 2'b10 : 2'b01;
      end
      TURN, RETURN: begin
        ack_nxt   = 2'b00;
        owner_nxt = 2'b11;
      end
      default: begin
        ack_nxt   = 2'b00;
        owner_nxt = 2'b00;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= CPU_RUN;
      turn_cnt     <= 2'd0;
      burst_cnt    <= '0;
      stall_writes <= 2'd0;
      winner       <= 1'b0;
      last_grant   <= 1'b1;
      cpu_ready    <= 1'b1;
      dma_ack      <= 2'b00;
      bus_owner    <= 2'b00;
    end else begin
      state        <= state_nxt;
      turn_cnt     <= turn_cnt_nxt;
      burst_cnt    <= burst_cnt_nxt;
      stall_writes <= stall_nxt;
      winner       <= winner_nxt;
      last_grant   <= last_grant_nxt;
      cpu_ready    <= ready_nxt;
      dma_ack      <= ack_nxt;
      bus_owner    <= owner_nxt;
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: directed scenarios plus random
// request traffic, scored against a countdown-based behavioural model.
module tb_dma_bus_arbiter;

  localparam int HO = 1;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_rw;
  logic [1:0] dma_req;
  logic       cpu_ready;
  logic [1:0] dma_ack;
  logic [1:0] bus_owner;
  logic [1:0] stall_writes;

  int n_checks = 0;
  int n_pass   = 0;
  logic [6:0] exp_q[$];

  localparam int M_CPU = 0, M_WAIT = 1, M_TURN = 2, M_DMA = 3, M_RET = 4;
  int m_mode, m_left, m_win, m_last, m_burst, m_stall;

  always #5 clk = ~clk;

  dma_bus_arbiter #(.HANDOFF_CYCLES(HO), .MAX_BURST(MB), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cpu_rw(cpu_rw), .dma_req(dma_req),
    .cpu_ready(cpu_ready), .dma_ack(dma_ack), .bus_owner(bus_owner),
    .stall_writes(stall_writes)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic m_reset();
    m_mode = M_CPU; m_left = 0; m_win = 0; m_last = 1; m_burst = 0; m_stall = 0;
  endtask

  task automatic m_to_cpu();
    m_mode = M_CPU; m_burst = 0; m_stall = 0;
  endtask

  task automatic m_to_return();
    if (HO == 0) m_to_cpu();
    else begin m_mode = M_RET; m_left = HO; end
  endtask

  task automatic m_grant(input logic [1:0] r);
    if (r == 2'b00) m_to_return();
    else begin
      if (r == 2'b11) m_win = 1 - m_last;
      else m_win = r[1] ? 1 : 0;
      m_last = m_win;
      m_mode = M_DMA;
    end
  endtask

  task automatic m_handoff(input logic [1:0] r);
    if (HO == 0) m_grant(r);
    else begin m_mode = M_TURN; m_left = HO; end
  endtask

  task automatic m_edge(input logic [1:0] r, input logic w);
    bit ex;
    case (m_mode)
      M_CPU:  if (r != 2'b00) m_mode = M_WAIT;
      M_WAIT: begin
        if (r == 2'b00) m_to_cpu();
        else if (w) m_handoff(r);
        else if (m_stall < 3) m_stall++;
      end
      M_TURN: begin m_left--; if (m_left == 0) m_grant(r); end
      M_DMA: begin
        m_burst++;
        ex = (MB > 0) && (m_burst >= MB);
        if (r[m_win] && !ex) m_mode = M_DMA;
        else if (r[1-m_win] && !ex) m_handoff(r);
        else m_to_return();
      end
      M_RET: begin m_left--; if (m_left == 0) m_to_cpu(); end
      default: m_reset();
    endcase
  endtask

  function automatic logic [6:0] m_out();
    logic       rdy;
    logic [1:0] ack, own;
    rdy = (m_mode == M_CPU);
    ack = 2'b00;
    own = 2'b00;
    if (m_mode == M_DMA) begin
      ack = (m_win == 1) ? 2'b10 : 2'b01;
      own = ack;
    end else if (m_mode == M_TURN || m_mode == M_RET) begin
      own = 2'b11;
    end
    return {rdy, ack, own, 2'(m_stall)};
  endfunction

  task automatic step(input logic [1:0] r, input logic w);
    dma_req = r;
    cpu_rw  = w;
    @(posedge clk);
    m_edge(r, w);
    exp_q.push_back(m_out());
    #1;
  endtask

  // Scoreboard monitor plus bus-safety invariants, sampled on the falling edge.
  always @(negedge clk) begin
    logic [6:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("scoreboard", {1'b0, cpu_ready, dma_ack, bus_owner, stall_writes}, {1'b0, e});
    end
    if (!reset) begin
      check("ack_never_11", {7'd0, dma_ack == 2'b11}, 8'd0);
      check("ack_low_when_ready", {7'd0, cpu_ready && (dma_ack != 2'b00)}, 8'd0);
    end
  end

  initial begin
    int c01, c10, crdy;
    logic [1:0] r;
    reset = 1'b1; dma_req = 2'b00; cpu_rw = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_state", {1'b0, cpu_ready, dma_ack, bus_owner, stall_writes}, 8'b0100_0000);
    @(negedge clk); #1 reset = 1'b0;

    // Single request on a read cycle, then drop.
    step(2'b01, 1'b1); check("t1_ready_low", {7'd0, cpu_ready}, 8'd0);
    step(2'b01, 1'b1); check("t1_turn_owner", {6'd0, bus_owner}, 8'd3);
    step(2'b01, 1'b1); check("t1_ack", {6'd0, dma_ack}, 8'd1);
    step(2'b01, 1'b1);
    step(2'b00, 1'b1); check("t1_return_owner", {6'd0, bus_owner}, 8'd3);
    step(2'b00, 1'b1); check("t1_ready_back", {7'd0, cpu_ready}, 8'd1);

    // Writes delay the grant and are counted.
    step(2'b10, 1'b0);
    repeat (3) step(2'b10, 1'b0);
    check("t2_stall3", {6'd0, stall_writes}, 8'd3);
    check("t2_no_ack", {6'd0, dma_ack}, 8'd0);
    step(2'b10, 1'b1); check("t2_turn", {6'd0, bus_owner}, 8'd3);
    step(2'b10, 1'b1); check("t2_ack", {6'd0, dma_ack}, 8'd2);
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);

    // Round robin with both masters requesting.
    c01 = 0; c10 = 0; crdy = 0;
    for (int i = 0; i < 24; i++) begin
      step(2'b11, 1'b1);
      if (dma_ack == 2'b01) c01++;
      if (dma_ack == 2'b10) c10++;
      if (cpu_ready) crdy++;
    end
    check("t3_dma0_cycles", 8'(c01), 8'd8);
    check("t3_dma1_cycles", 8'(c10), 8'd4);
    check("t3_cpu_cycles", 8'(crdy), 8'd3);
    step(2'b00, 1'b1);

    // Master switch mid-burst.
    repeat (3) step(2'b01, 1'b1);
    step(2'b11, 1'b1);
    step(2'b10, 1'b1); check("t4_turn", {5'd0, cpu_ready, bus_owner}, 8'd3);
    step(2'b10, 1'b1); check("t4_dma1", {5'd0, cpu_ready, dma_ack}, 8'd2);
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);

    // Request withdrawn while waiting on writes.
    step(2'b01, 1'b0); check("t5_ready_low", {7'd0, cpu_ready}, 8'd0);
    step(2'b00, 1'b0); check("t5_back", {5'd0, cpu_ready, dma_ack}, 8'd4);

    // Asynchronous reset during a DMA1 grant.
    repeat (3) step(2'b10, 1'b1);
    check("t6_dma1", {6'd0, dma_ack}, 8'd2);
    @(negedge clk); #1 reset = 1'b1;
    #1 check("t6_async", {3'd0, cpu_ready, dma_ack, bus_owner}, 8'b0001_0000);
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1'b0;
    repeat (3) step(2'b11, 1'b1);
    check("t6_dma0_first", {6'd0, dma_ack}, 8'd1);
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);

    // Random request traffic.
    r = 2'b00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) r[0] = ~r[0];
      if ($urandom_range(0, 7) == 0) r[1] = ~r[1];
      step(r, $urandom_range(0, 3) != 0);
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
